float_norm_arbiter: RTL and testbench
=====================================

# float_norm_arbiter

Sequential controller that shares one iterative 8-bit float normalizer between two requesters. The normalizer shifts the mantissa left one bit per cycle until the MSB is 1, and produces the normalized value F and the position code P of the leading one. Zero is handled as P=0, F=0. Two requesters are served round-robin through a req/ack handshake. The block sits between the experiment's input sources and the display/result path, and replaces the combinational normalizer where area or sharing matters.

## Interface
- No parameters; widths are fixed at 8-bit data and 3-bit position.
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request lines; req[i] belongs to requester i
- U0  in  8  operand of requester 0; must be stable while req[0]=1
- U1  in  8  operand of requester 1; must be stable while req[1]=1
- F  out  8  normalized result; registered; holds last result
- P  out  3  leading-one position (7 = bit 7 … 0 = bit 0 or zero input); registered; holds last result
- ack  out  2  one-cycle completion pulse; ack[i] means F/P belong to requester i
- busy  out  1  high from grant until the DONE cycle, exclusive
- owner  out  1  index of the requester currently or last served

## Operation
- Internal registers:
  - sh[7:0]: working mantissa.
  - cnt[2:0]: position counter.
  - last: last-served index.
  - state ∈ {IDLE, SHIFT, DONE}.
- IDLE:
  - If req==00, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If req==11, grant the requester ≠ last.
  - On grant: sh←U of the winner, cnt←7, owner←winner, busy←1, state←SHIFT.
- SHIFT, evaluated every cycle:
  - If sh[7]==1 or cnt==0: F←sh, P←cnt, ack[owner]←1, busy←0, last←owner, state←DONE.
  - Otherwise: sh←sh<<1 with zero fill, cnt←cnt−1.
- DONE:
  - ack is high for exactly this cycle.
  - Unconditional transition: ack←00, state←IDLE.
- Arithmetic: the result equals the combinational normalizer, F = U<<(7−P) truncated to 8 bits, and P = index of the leading one.
  - U=0x00 gives F=0x00, P=0.
  - U=0x01 gives F=0x80, P=0.
- Requester protocol:
  - Raise req[i] with the operand stable.
  - Hold req[i] until ack[i] is seen.
  - Deassert req[i] at the clock edge that ends the ack cycle.
  - A req still high in the IDLE cycle after DONE is a new request.
- The operand is sampled only at the grant edge; later changes on U0/U1 are ignored.
- If the owner drops req mid-operation, the operation still completes and ack is still pulsed.
- A req from the non-owner during SHIFT or DONE is held off. It is considered again in IDLE.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, F=0x00, P=0, ack=00, busy=0, owner=0.
  - last=1, so requester 0 wins the first tie.
  - sh=0, cnt=0.
- Reset takes effect immediately, including mid-operation. There is no ack for the aborted operation.
- After rst_n rises, the first grant can occur at the next rising edge.
- Latency, with E0 = the grant edge and k = number of leading zeros (k capped at 7):
  - SHIFT runs k+1 cycles.
  - ack, F and P are valid in the cycle after edge E0+k+1.
  - Minimum: U[7]=1 gives ack after 2 edges.
  - Maximum: U≤0x01 gives ack after 9 edges.
- Back-to-back: IDLE→grant costs one cycle, so the throughput for a 1xxxxxxx operand is one result per 3 cycles.
- F and P change only at the SHIFT→DONE edge. They are stable at all other times.
- busy falls at the same edge that ack rises.

## Test plan
- Reset, then req=01, U0=0xB4 → ack[0] pulse 2 edges after grant; F=0xB4, P=7, owner=0; busy high for exactly 1 cycle before ack.
- req=10, U1=0x13 → ack[1] 5 edges after grant; F=0x98, P=4; intermediate busy=1 for 4 cycles.
- U0=0x00 and U0=0x01 in separate requests → both ack 9 edges after grant; 0x00 gives F=0x00, P=0; 0x01 gives F=0x80, P=0.
- req=11 held continuously, U0=0x40, U1=0x20 → service order 0,1,0,1; outputs alternate F=0x80/P=6 and F=0x80/P=5; exactly one ack bit per completion.
- Assert rst_n=0 during the third SHIFT cycle of U0=0x01 → outputs go to reset values without a clock; no ack; after release, req=01 with U0=0x81 yields F=0x81, P=7.
- Change U0 from 0x08 to 0xFF one cycle after grant, and drop req[0] mid-SHIFT → result F=0x80, P=3; ack[0] still pulses once.

Source files
------------

// File: rtl/float_norm_arbiter.sv
// Shares one iterative 8-bit leading-one normalizer between two requesters.
// Requests are granted round-robin; results come back with a one-cycle ack pulse.
module float_norm_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] U0,
  input  logic [7:0] U1,
  output logic [7:0] F,
  output logic [2:0] P,
  output logic [1:0] ack,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [7:0] f_q, f_d;
  logic [2:0] p_q, p_d;
  logic [1:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       owner_q, owner_d;
  logic       grant;
  logic       winner;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    f_d     = f_q;
    p_d     = p_q;
    ack_d   = 2'b00;
    busy_d  = busy_q;
    owner_d = owner_q;
    grant   = 1'b0;
    winner  = 1'b0;

    case (state_q)
      StIdle: begin
        case (req)
          2'b01: begin
            grant  = 1'b1;
            winner = 1'b0;
          end
          2'b10: begin
            grant  = 1'b1;
            winner = 1'b1;
          end
          2'b11: begin
            // Tie goes to whoever was not served last.
            grant  = 1'b1;
            winner = ~last_q;
          end
          default: grant = 1'b0;
        endcase
        if (grant) begin
          sh_d    = winner ? U1 : U0;
          cnt_d   = 3'd7;
          owner_d = winner;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sh_q[7] || (cnt_q == 3'd0)) begin
          f_d     = sh_q;
          p_d     = cnt_q;
          ack_d   = owner_q ? 2'b10 : 2'b01;
          busy_d  = 1'b0;
          last_d  = owner_q;
          state_d = StDone;
        end else begin
          sh_d  = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= 8'h00;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      f_q     <= 8'h00;
      p_q     <= 3'd0;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      f_q     <= f_d;
      p_q     <= p_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign F     = f_q;
  assign P     = p_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_float_norm_arbiter.sv
// Directed, table-driven bench for float_norm_arbiter with hand-computed results
// plus sequences for round-robin, mid-operation reset and operand/req changes.
module tb_float_norm_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] U0, U1;
  logic [7:0] F;
  logic [2:0] P;
  logic [1:0] ack;
  logic       busy;
  logic       owner;

  int checks   = 0;
  int failures = 0;

  float_norm_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .U0   (U0),
    .U1   (U1),
    .F    (F),
    .P    (P),
    .ack  (ack),
    .busy (busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] u0;
    logic [7:0] u1;
    logic [7:0] f;
    logic [2:0] p;
    logic [1:0] ack;
    int         edges;  // grant edge counted as edge 1
    logic       owner;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE through the ack cycle and one IDLE cycle after it.
  task automatic do_op(input vec_t v, input string tag);
    int         n;
    int         busy_cyc;
    int         unstable;
    logic [7:0] f0;
    logic [2:0] p0;
    f0 = F;
    p0 = P;
    req = v.req;
    U0 = v.u0;
    U1 = v.u1;
    step();
    n = 1;
    busy_cyc = 0;
    unstable = 0;
    chk({tag, " owner"}, int'(owner), int'(v.owner));
    while (ack == 2'b00 && n < 20) begin
      if (busy) busy_cyc++;
      if (F !== f0 || P !== p0) unstable++;
      step();
      n++;
    end
    chk({tag, " latency"}, n, v.edges);
    chk({tag, " ack"}, int'(ack), int'(v.ack));
    chk({tag, " F"}, int'(F), int'(v.f));
    chk({tag, " P"}, int'(P), int'(v.p));
    chk({tag, " busy_at_ack"}, int'(busy), 0);
    chk({tag, " busy_cycles"}, busy_cyc, v.edges - 1);
    chk({tag, " F/P held"}, unstable, 0);
    req = 2'b00;
    step();
    chk({tag, " ack_cleared"}, int'(ack), 0);
    chk({tag, " F_hold"}, int'(F), int'(v.f));
  endtask

  initial begin
    int   n;
    int   acks;
    vec_t v;

    //          req    u0     u1     f      p     ack    edges owner
    vecs[0] = '{2'b01, 8'hB4, 8'h00, 8'hB4, 3'd7, 2'b01, 2, 1'b0};
    vecs[1] = '{2'b10, 8'h00, 8'h13, 8'h98, 3'd4, 2'b10, 5, 1'b1};
    vecs[2] = '{2'b01, 8'h00, 8'h77, 8'h00, 3'd0, 2'b01, 9, 1'b0};
    vecs[3] = '{2'b01, 8'h01, 8'h00, 8'h80, 3'd0, 2'b01, 9, 1'b0};
    vecs[4] = '{2'b10, 8'h00, 8'hFF, 8'hFF, 3'd7, 2'b10, 2, 1'b1};
    vecs[5] = '{2'b10, 8'h55, 8'h2A, 8'hA8, 3'd5, 2'b10, 4, 1'b1};

    rst_n = 1'b0;
    req = 2'b00;
    U0 = 8'h00;
    U1 = 8'h00;
    step();
    step();
    chk("reset F", int'(F), 0);
    chk("reset P", int'(P), 0);
    chk("reset ack", int'(ack), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset owner", int'(owner), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters held: last served was 1, so order is 0,1,0,1.
    req = 2'b11;
    U0 = 8'h40;
    U1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      n = 1;
      while (ack == 2'b00 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d ack", i), int'(ack), (i % 2 == 1) ? 2 : 1);
      chk($sformatf("rr%0d owner", i), int'(owner), i % 2);
      chk($sformatf("rr%0d F", i), int'(F), 8'h80);
      chk($sformatf("rr%0d P", i), int'(P), (i % 2 == 1) ? 5 : 6);
    end
    req = 2'b00;
    step();
    step();
    chk("rr idle busy", int'(busy), 0);

    // Asynchronous reset during the third SHIFT cycle of U0=0x01.
    req = 2'b01;
    U0 = 8'h01;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst F", int'(F), 0);
    chk("midrst P", int'(P), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst ack", int'(ack), 0);
    chk("midrst owner", int'(owner), 0);
    req = 2'b00;
    step();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack != 2'b00) acks++;
    end
    chk("midrst no ack", acks, 0);
    v = '{2'b01, 8'h81, 8'h00, 8'h81, 3'd7, 2'b01, 2, 1'b0};
    do_op(v, "postrst");

    // Operand changes after grant and req drops mid-SHIFT: 0x08 still wins.
    req = 2'b01;
    U0 = 8'h08;
    step();
    U0 = 8'hFF;
    step();
    step();
    req = 2'b00;
    n = 3;
    while (ack == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk("drop latency", n, 6);
    chk("drop ack", int'(ack), 1);
    chk("drop F", int'(F), 8'h80);
    chk("drop P", int'(P), 3);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack != 2'b00) acks++;
    end
    chk("drop single ack", acks, 0);
    chk("drop idle busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
